// File: rtl/kgain2_serial.sv
// Serial 2x2 Kalman gain multiplier K = M * inv(S): one element per cycle through
// two truncating fixed-point multipliers and one wrapping adder.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module kgain2_serial #(
  parameter int N    = `FXP_N,
  parameter int FRAC = `FXP_FRAC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] m00,
  input  logic signed [N-1:0] m01,
  input  logic signed [N-1:0] m10,
  input  logic signed [N-1:0] m11,
  input  logic signed [N-1:0] IA,
  input  logic signed [N-1:0] IB,
  input  logic signed [N-1:0] IC,
  input  logic signed [N-1:0] ID,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] K00,
  output logic signed [N-1:0] K01,
  output logic signed [N-1:0] K10,
  output logic signed [N-1:0] K11
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E0   = 3'd1,
    S_E1   = 3'd2,
    S_E2   = 3'd3,
    S_E3   = 3'd4
  } state_t;

  state_t r_state;
  logic signed [N-1:0] r_m00, r_m01, r_m10, r_m11;
  logic signed [N-1:0] r_ia, r_ib, r_ic, r_id;
  logic signed [N-1:0] r_sk00, r_sk01, r_sk10;
  logic signed [N-1:0] r_k00, r_k01, r_k10, r_k11;
  logic                r_busy, r_done;

  logic                  w_row_hi, w_col_hi;
  logic signed [N-1:0]   w_a0, w_a1, w_b0, w_b1;
  logic signed [2*N-1:0] w_prod0, w_prod1;
  logic signed [N-1:0]   w_t0, w_t1, w_sum;

  // E0/E1 use the top row of M, E2/E3 the bottom; E1/E3 use the right column of inv(S).
  assign w_row_hi = (r_state == S_E2) || (r_state == S_E3);
  assign w_col_hi = (r_state == S_E1) || (r_state == S_E3);
  assign w_a0 = w_row_hi ? r_m10 : r_m00;
  assign w_a1 = w_row_hi ? r_m11 : r_m01;
  assign w_b0 = w_col_hi ? r_ib  : r_ia;
  assign w_b1 = w_col_hi ? r_id  : r_ic;

  // Full-width signed products, floor-shifted by FRAC, then wrapped to N bits.
  assign w_prod0 = (2*N)'(w_a0) * (2*N)'(w_b0);
  assign w_prod1 = (2*N)'(w_a1) * (2*N)'(w_b1);
  assign w_t0    = N'(w_prod0 >>> FRAC);
  assign w_t1    = N'(w_prod1 >>> FRAC);
  assign w_sum   = w_t0 + w_t1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_m00   <= '0;
      r_m01   <= '0;
      r_m10   <= '0;
      r_m11   <= '0;
      r_ia    <= '0;
      r_ib    <= '0;
      r_ic    <= '0;
      r_id    <= '0;
      r_sk00  <= '0;
      r_sk01  <= '0;
      r_sk10  <= '0;
      r_k00   <= '0;
      r_k01   <= '0;
      r_k10   <= '0;
      r_k11   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m00   <= m00;
            r_m01   <= m01;
            r_m10   <= m10;
            r_m11   <= m11;
            r_ia    <= IA;
            r_ib    <= IB;
            r_ic    <= IC;
            r_id    <= ID;
            r_busy  <= 1'b1;
            r_state <= S_E0;
          end
        end
        S_E0: begin
          r_sk00  <= w_sum;
          r_state <= S_E1;
        end
        S_E1: begin
          r_sk01  <= w_sum;
          r_state <= S_E2;
        end
        S_E2: begin
          r_sk10  <= w_sum;
          r_state <= S_E3;
        end
        S_E3: begin
          r_k00   <= r_sk00;
          r_k01   <= r_sk01;
          r_k10   <= r_sk10;
          r_k11   <= w_sum;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign K00  = r_k00;
  assign K01  = r_k01;
  assign K10  = r_k10;
  assign K11  = r_k11;

endmodule

// File: tb/tb_kgain2_serial.sv
// Scoreboard bench for kgain2_serial (N=16, FRAC=8): directed jobs with hand-computed gains.
`timescale 1ns/1ps

module tb_kgain2_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] m00, m01, m10, m11, ia, ib, ic, id;
  logic        busy, done;
  logic [15:0] k00, k01, k10, k11;

  kgain2_serial #(.N(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .m00(m00), .m01(m01), .m10(m10), .m11(m11),
    .IA(ia), .IB(ib), .IC(ic), .ID(id),
    .busy(busy), .done(done),
    .K00(k00), .K01(k01), .K10(k10), .K11(k11)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e00, e01, e10, e11;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          dones = 0;
  int          jobs = 0;
  logic [63:0] hold = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: pops an expectation on every done, otherwise K must hold its last value.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        dones++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got K=%h %h %h %h with no job pending", k00, k01, k10, k11);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("job%0d_K", e.tag), {k00, k01, k10, k11}, {e.e00, e.e01, e.e10, e.e11});
          $display("job %0d: K=%h %h %h %h", e.tag, k00, k01, k10, k11);
          hold = {e.e00, e.e01, e.e10, e.e11};
        end
      end else begin
        chk("K_hold", {k00, k01, k10, k11}, hold);
      end
    end
  end

  task automatic set_ops(input logic [15:0] a00, a01, a10, a11, b0, b1, b2, b3);
    m00 = a00; m01 = a01; m10 = a10; m11 = a11;
    ia = b0; ib = b1; ic = b2; id = b3;
  endtask

  task automatic push_exp(input logic [15:0] e00, e01, e10, e11);
    exp_t e;
    e.e00 = e00; e.e01 = e01; e.e10 = e10; e.e11 = e11;
    e.tag = jobs;
    sb.push_back(e);
    jobs++;
  endtask

  task automatic run_job(input logic [15:0] a00, a01, a10, a11, b0, b1, b2, b3,
                         input logic [15:0] e00, e01, e10, e11);
    int cyc, bc;
    logic got;
    set_ops(a00, a01, a10, a11, b0, b1, b2, b3);
    push_exp(e00, e01, e10, e11);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; bc = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bc++;
      if (done === 1'b1) got = 1'b1;
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("done_latency", 64'(cyc), 64'd5);
    chk("busy_cycles", 64'(bc), 64'd4);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_K", {k00, k01, k10, k11}, 64'd0);
    rst_n = 1'b1;

    // identity, true inverse, floor truncation, wraps, mixed signs
    run_job(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100, 16'h0000, 16'h0000, 16'h0100,
            16'h0100, 16'h0200, 16'h0300, 16'h0400);
    run_job(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFE00, 16'h0100, 16'h0180, 16'hFF80,
            16'h0100, 16'h0000, 16'h0000, 16'h0100);
    run_job(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000,
            16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_job(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 16'h0000,
            16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    run_job(16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000,
            16'hFE00, 16'h0000, 16'h0000, 16'h0000);
    run_job(16'h7F00, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000,
            16'h8000, 16'h0000, 16'h0000, 16'h0000);
    run_job(16'hFF00, 16'h0080, 16'h0200, 16'hFE80, 16'h0100, 16'h0040, 16'h0200, 16'hFFC0,
            16'h0000, 16'hFFA0, 16'hFF00, 16'h00E0);

    // start re-pulsed at t2 and t4 with changed operands: only the t0 job completes
    set_ops(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    push_exp(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    set_ops(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFE00, 16'h0100, 16'h0180, 16'hFF80);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_test_done", 64'(done), 64'd1);
    chk("busy_test_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    chk("busy_test_idle", 64'(busy), 64'd0);

    // reset during E2 aborts the job and clears outputs immediately
    d0 = dones;
    set_ops(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100, 16'h0000, 16'h0000, 16'h0100);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    hold = '0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_K", {k00, k01, k10, k11}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", 64'(dones - d0), 64'd0);
    chk("midrst_K_after", {k00, k01, k10, k11}, 64'd0);

    run_job(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'hFE00, 16'h0100, 16'h0180, 16'hFF80,
            16'h0100, 16'h0000, 16'h0000, 16'h0100);
    repeat (3) @(negedge clk);

    chk("queue_empty", 64'(sb.size()), 64'd0);
    chk("done_count", 64'(dones), 64'(jobs));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
